btn_debounce: RTL
=================

# btn_debounce

Debounces and event-codes the four board push-buttons (btn0..btn3, FB1_13..FB1_16), the input-side counterpart of the free-running LED toggle counter. Each raw button is synchronised into the GCK clock domain, qualified by a shared prescaled tick and a per-button confirm state machine. The block emits a clean level plus single-cycle press, release and (optionally) long-press strobes for downstream control logic.

## Interface
- `NUM_BTN`, default 4: number of independent button channels.
- `PRESCALE_BITS`, default 16: tick period is 2^PRESCALE_BITS clocks (1.31 ms at 50 MHz).
- `STABLE_TICKS`, default 8: consecutive ticks of a stable level required to accept a transition. Must be ≥ 2.
- `LONG_TICKS`, default 512: ticks held before the long-press strobe. Must be ≥ 2.
- `clk`  in  1  system clock, BUFG output of clk_50Mhz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  NUM_BTN  raw pad inputs, active-high, asynchronous to `clk`.
- `btn_level`  out  NUM_BTN  debounced level; 1 = pressed.
- `btn_press`  out  NUM_BTN  one-cycle strobe on accepted press.
- `btn_release`  out  NUM_BTN  one-cycle strobe on accepted release.
- `btn_long`  out  NUM_BTN  one-cycle strobe after LONG_TICKS held; constant 0 unless `BTN_LONGPRESS_EN`.

## Operation
- Synchroniser: two flops per bit. `sync` is `btn_raw` delayed 2 clocks and resets to 0.
- Prescaler: a PRESCALE_BITS-wide free-running up-counter that resets to 0 and wraps. `tick` is 1 for exactly one cycle when the counter equals all-ones. All channels share it.
- Per-channel FSM, with `cnt` of width clog2(STABLE_TICKS):
  - IDLE (level 0):
    - `sync`=1 → CONF_P, cnt←0.
  - CONF_P (level 0):
    - `sync`=0 → IDLE with no strobe. This is a bounce.
    - Else, on `tick`: if cnt==STABLE_TICKS-1 → PRESSED and pulse `btn_press`; otherwise cnt++.
  - PRESSED (level 1):
    - `sync`=0 → CONF_R, cnt←0.
  - CONF_R (level 1):
    - `sync`=1 → PRESSED with no strobe.
    - Else, on `tick`: if cnt==STABLE_TICKS-1 → IDLE and pulse `btn_release`; otherwise cnt++.
- A bounce back while confirming always discards progress. The next attempt restarts cnt at 0.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes in the same cycle.
- All outputs are registered. Reset values are: FSM=IDLE, cnt=0, long counter=0, prescaler=0, and every output=0.
- Assertion of `rst_n` mid-confirm or while held aborts with no strobe. After release of reset, a button already held is reported as a fresh press once it has been confirmed.

## Timing
- `btn_level` rises in the same cycle `btn_press` pulses. It falls in the same cycle `btn_release` pulses.
- Press latency from a `btn_raw` edge that then stays stable: 2 (sync) + 1 (IDLE→CONF_P) + wait until the STABLE_TICKS-th tick + 1 (registered output).
  - Bound: between (STABLE_TICKS-1)·2^P+4 and STABLE_TICKS·2^P+3 clocks.
- Release latency is symmetric.
- A `btn_raw` glitch shorter than 2^P clocks before any tick never produces a strobe.
- The strobes `btn_press`, `btn_release` and `btn_long` are never high for more than 1 consecutive cycle per channel.
- For a given channel, `btn_press` and `btn_release` are never asserted in the same cycle.

## Configuration
- `BTN_LONGPRESS_EN` defined:
  - Each channel has a long counter of width clog2(LONG_TICKS). It is cleared on entering PRESSED and increments on `tick` while in PRESSED or CONF_R.
  - When the long counter reaches LONG_TICKS-1 on a tick, `btn_long` pulses once and the counter saturates, so there is no repeat.
  - The long counter is cleared on return to IDLE. A bounce into CONF_R and back does not clear it.
- `BTN_LONGPRESS_EN` undefined: no long counters are synthesised and `btn_long` is tied to 0. The port list is unchanged.

## Test plan
All scenarios use PRESCALE_BITS=2, STABLE_TICKS=3 and LONG_TICKS=5.

- Reset: hold `rst_n`=0 with `btn_raw`=4'hF → all outputs 0. After release, `btn_level`=4'hF within 16 clocks, and each `btn_press` bit pulses exactly once.
- Clean press/release on btn0: raise the input and hold 40 clocks → `btn_press[0]` fires once between clocks 12 and 15 after the edge, and `btn_level[0]`=1. Drop the input → `btn_release[0]` fires once, 12–15 clocks later.
- Bounce: toggle btn1 every 3 clocks for 30 clocks, then hold low → no strobes on any channel and `btn_level[1]` stays 0.
- Simultaneous: raise btn2 and btn3 in the same cycle → `btn_press[2]` and `btn_press[3]` are asserted in the same cycle, and channels 0–1 stay 0.
- Mid-confirm reset: pulse `rst_n` low 8 clocks after a btn0 press edge → no press strobe before reset. After release, a single press is reported 12–15 clocks later.
- Long press (`BTN_LONGPRESS_EN`): hold btn0 for 60 clocks → `btn_long[0]` pulses exactly once, 16–20 clocks after `btn_press[0]`. With the macro undefined, `btn_long` stays 0.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises, debounces and event-codes NUM_BTN push-buttons.
// Each channel emits a registered level plus one-cycle press/release strobes.
// Define BTN_LONGPRESS_EN to build the per-channel long-press timer; without
// it btn_long is tied to 0 and no long counters exist.
module btn_debounce #(
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned PRESCALE_BITS = 16,
    parameter int unsigned STABLE_TICKS  = 8,
    parameter int unsigned LONG_TICKS    = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONF_P,
        S_PRESSED,
        S_CONF_R
    } state_t;

    if (STABLE_TICKS < 2 || LONG_TICKS < 2) begin : g_param_check
        $error("btn_debounce: STABLE_TICKS and LONG_TICKS must be >= 2");
    end

    logic [NUM_BTN-1:0]       r_sync1;
    logic [NUM_BTN-1:0]       r_sync2;
    logic [PRESCALE_BITS-1:0] r_presc;
    logic                     w_tick;

    // Two-flop synchroniser bringing the pad inputs into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = &r_presc;

    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;

        // Confirm FSM: a level change is accepted after STABLE_TICKS ticks without bounce
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (r_sync2[g]) begin
                            r_state <= S_CONF_P;
                            r_cnt   <= '0;
                        end
                    end
                    S_CONF_P: begin
                        if (!r_sync2[g]) begin
                            r_state <= S_IDLE;
                        end else if (w_tick) begin
                            if (r_cnt == CNT_LAST) begin
                                r_state <= S_PRESSED;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_PRESSED: begin
                        if (!r_sync2[g]) begin
                            r_state <= S_CONF_R;
                            r_cnt   <= '0;
                        end
                    end
                    S_CONF_R: begin
                        if (r_sync2[g]) begin
                            r_state <= S_PRESSED;
                        end else if (w_tick) begin
                            if (r_cnt == CNT_LAST) begin
                                r_state   <= S_IDLE;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;

`ifdef BTN_LONGPRESS_EN
        localparam int unsigned       LONG_W    = $clog2(LONG_TICKS);
        localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TICKS - 1);
        localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_TICKS - 2);

        logic [LONG_W-1:0] r_long_cnt;
        logic              r_long;

        // Long-press timer: held at 0 while released, so it starts from 0 on every
        // new press; a CONF_R bounce keeps the count. Saturates after firing once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_long_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (r_state == S_IDLE || r_state == S_CONF_P) begin
                    r_long_cnt <= '0;
                end else if (w_tick && r_long_cnt != LONG_LAST) begin
                    r_long_cnt <= r_long_cnt + 1'b1;
                    r_long     <= (r_long_cnt == LONG_PRE);
                end
            end
        end

        assign btn_long[g] = r_long;
`else
        assign btn_long[g] = 1'b0;
`endif
    end

endmodule
